// File: rtl/mul8_seq_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier built on a 4x4 core.
package mul8_seq_pkg;

   localparam int NIB_W = 4;
   localparam int OP_W  = 2 * NIB_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   // Pass order: low x low, low(a) x high(b), high(a) x low(b), high x high.
   localparam logic [1:0] PASS_LL = 2'd0;
   localparam logic [1:0] PASS_LH = 2'd1;
   localparam logic [1:0] PASS_HL = 2'd2;
   localparam logic [1:0] PASS_HH = 2'd3;

   // Left shift applied to the core's partial product in each pass: {0,4,4,8}.
   function automatic logic [3:0] pass_shift(input logic [1:0] pass);
      case (pass)
         PASS_LL:          return 4'd0;
         PASS_LH, PASS_HL: return 4'd4;
         default:          return 4'd8;
      endcase
   endfunction

endpackage

// File: rtl/mul4x4_array.sv
// Shared 4x4 multiplier core: picks the operand nibbles for the current pass and
// multiplies them with a plain AND / ripple full-adder array.
module mul4x4_array
   import mul8_seq_pkg::*;
(
   input  logic [OP_W-1:0]    a_i,
   input  logic [OP_W-1:0]    b_i,
   input  logic [1:0]         pass_i,
   output logic [2*NIB_W-1:0] prod_o
);

   logic [NIB_W-1:0]                  nib_a;
   logic [NIB_W-1:0]                  nib_b;
   logic [NIB_W-1:0][2*NIB_W-1:0]     row_sum;
   logic [2*NIB_W-1:0]                pp_row;
   logic                              carry;

   // Select the high or low nibble of each operand for this pass.
   always_comb begin
      nib_a = (pass_i == PASS_HL || pass_i == PASS_HH) ? a_i[OP_W-1:NIB_W] : a_i[NIB_W-1:0];
      nib_b = (pass_i == PASS_LH || pass_i == PASS_HH) ? b_i[OP_W-1:NIB_W] : b_i[NIB_W-1:0];
   end

   // Array multiply: each row adds one shifted partial product with a ripple of full adders.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
      row_sum    = '0;
      pp_row     = '0;
      carry      = 1'b0;
      row_sum[0] = {{NIB_W{1'b0}}, nib_a & {NIB_W{nib_b[0]}}};
      for (int r = 1; r < NIB_W; r++) begin
         pp_row = {{NIB_W{1'b0}}, nib_a & {NIB_W{nib_b[r]}}} << r;
         carry  = 1'b0;
         for (int k = 0; k < 2*NIB_W; k++) begin
            row_sum[r][k] = row_sum[r-1][k] ^ pp_row[k] ^ carry;
            carry         = (row_sum[r-1][k] & pp_row[k]) | (carry & (row_sum[r-1][k] ^ pp_row[k]));
         end
      end
      prod_o = row_sum[NIB_W-1];
   end

endmodule

// File: rtl/mul8_seq_ctrl.sv
// Round-robin sequencer that computes 8x8 -> 16-bit products in four nibble passes
// on one shared 4x4 core, with valid/ready handshakes on the request and result sides.
module mul8_seq_ctrl #(
   parameter int NUM_REQ = 2,
   parameter int OP_W    = 8,
   parameter int NIB_W   = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ*OP_W-1:0]     req_a,
   input  logic [NUM_REQ*OP_W-1:0]     req_b,
   output logic                        res_valid,
   input  logic                        res_ready,
   output logic [2*OP_W-1:0]           res_product,
   output logic [$clog2(NUM_REQ)-1:0]  res_id,
   output logic                        busy
);

   import mul8_seq_pkg::state_e;
   import mul8_seq_pkg::IDLE;
   import mul8_seq_pkg::CALC;
   import mul8_seq_pkg::DONE;
   import mul8_seq_pkg::PASS_LL;
   import mul8_seq_pkg::PASS_HH;
   import mul8_seq_pkg::pass_shift;

   localparam int ID_W   = $clog2(NUM_REQ);
   localparam int PROD_W = 2 * OP_W;

   state_e               state_q;
   logic [OP_W-1:0]      a_q;
   logic [OP_W-1:0]      b_q;
   logic [1:0]           pass_q;
   logic [PROD_W-1:0]    acc_q;
   logic [PROD_W-1:0]    acc_d;
   logic [ID_W-1:0]      rr_ptr_q;
   logic [ID_W-1:0]      rr_ptr_d;
   logic                 res_valid_q;
   logic [PROD_W-1:0]    res_product_q;
   logic [ID_W-1:0]      res_id_q;
   logic [2*NIB_W-1:0]   core_prod;
   logic                 grant_valid;
   logic [ID_W-1:0]      grant_id;
   int                   scan_idx;

   mul4x4_array u_core (
      .a_i    (a_q),
      .b_i    (b_q),
      .pass_i (pass_q),
      .prod_o (core_prod)
   );

   // Round-robin scan: first valid requester at or after rr_ptr, wrapping at NUM_REQ.
   always_comb begin
      grant_valid = 1'b0;
      grant_id    = '0;
      scan_idx    = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = int'(rr_ptr_q) + k;
         if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
         if (!grant_valid && req_valid[scan_idx]) begin
            grant_valid = 1'b1;
            grant_id    = ID_W'(scan_idx);
         end
      end
      rr_ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
   end

   // Ready goes only to the granted requester, only in IDLE, and never while reset is held.
   always_comb begin
      req_ready = '0;
      if (rst_n && state_q == IDLE && grant_valid) req_ready[grant_id] = 1'b1;
   end

   // Accumulate the current pass's partial product at its nibble weight.
   always_comb begin
      acc_d = acc_q + (PROD_W'(core_prod) << pass_shift(pass_q));
   end

   // Sequencer FSM with registered result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         a_q           <= '0;
         b_q           <= '0;
         pass_q        <= PASS_LL;
         acc_q         <= '0;
         rr_ptr_q      <= '0;
         res_valid_q   <= 1'b0;
         res_product_q <= '0;
         res_id_q      <= '0;
      end else begin
         // NOTE: state uses <= so every register here samples the values from before the edge.
         case (state_q)
            IDLE: begin
               if (grant_valid) begin
                  a_q      <= req_a[grant_id*OP_W +: OP_W];
                  b_q      <= req_b[grant_id*OP_W +: OP_W];
                  res_id_q <= grant_id;
                  acc_q    <= '0;
                  pass_q   <= PASS_LL;
                  rr_ptr_q <= rr_ptr_d;
                  state_q  <= CALC;
               end
            end
            CALC: begin
               acc_q  <= acc_d;
               pass_q <= pass_q + 2'd1;
               if (pass_q == PASS_HH) begin
                  res_product_q <= acc_d;
                  res_valid_q   <= 1'b1;
                  state_q       <= DONE;
               end
            end
            DONE: begin
               if (res_ready) begin
                  res_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign res_valid   = res_valid_q;
   assign res_product = res_product_q;
   assign res_id      = res_id_q;
   assign busy        = (state_q != IDLE);

endmodule
